// File: rtl/mc_pkg.sv
// Shared types for the multicycle RV32I control unit:
// FSM states, opcodes, ALUOp and ALUControl encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_FN  = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

endpackage

// File: rtl/mc_control_fsm_aludec.sv
// ALU decoder: maps ALUOp, funct3, funct7b5 and op[5] to ALUControl.
// Ports: alu_op_i, op5_i, funct3_i, funct7b5_i -> alu_ctrl_o.
module mc_control_fsm_aludec
  import mc_pkg::*;
(
  input  aluop_t     alu_op_i,
  input  logic       op5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    unique case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      default: begin
        unique case (funct3_i)
          // subi does not exist, so op[5] gates sub
          3'b000: alu_ctrl_o = (funct7b5_i & op5_i) ?
                               ALU_SUB : ALU_ADD;
          3'b010: alu_ctrl_o = ALU_SLT;
          3'b110: alu_ctrl_o = ALU_OR;
          3'b111: alu_ctrl_o = ALU_AND;
          3'b101: alu_ctrl_o = ALU_SRL;
          3'b100: alu_ctrl_o = ALU_XOR;
          3'b001: alu_ctrl_o = ALU_SLL;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM (lw, sw, R, I, beq, jal) with memory-ready
// wait; optional retired-instruction counter under MC_PERF_CNT_EN.
// Ports: clk, reset, op, funct3, funct7b5, zero, mem_ready in;
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, RegWrite, ALUControl, illegal, instret out.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state_q, state_d;
  aluop_t alu_op;
  logic   pc_upd, branch;
  logic   ir_wr, mem_wr, reg_wr, ill;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_upd    = 1'b0;
    branch    = 1'b0;
    ir_wr     = 1'b0;
    mem_wr    = 1'b0;
    reg_wr    = 1'b0;
    ill       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    unique case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_upd  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default: begin
            state_d = FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FN;
        state_d = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FN;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_wr  = 1'b1;
        state_d = FETCH;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_upd  = 1'b1;
        state_d = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Writes are suppressed combinationally while reset is high so an
  // aborted instruction cannot commit anything in its last cycle.
  assign PCWrite  = ~reset & (pc_upd | (branch & zero));
  assign IRWrite  = ~reset & ir_wr;
  assign MemWrite = ~reset & mem_wr;
  assign RegWrite = ~reset & reg_wr;
  assign illegal  = ~reset & ill;

  mc_control_fsm_aludec u_aludec (
    .alu_op_i   (alu_op),
    .op5_i      (op[5]),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (ALUControl)
  );

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // Only completing states count; the illegal DECODE->FETCH path does not.
  assign retire = (state_d == FETCH) &&
                  (state_q == MEMWB || state_q == MEMWRITE ||
                   state_q == ALUWB || state_q == BEQ);

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clk) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = reset ? '0 : instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed table-driven bench for mc_control_fsm.
// Each vector holds one cycle's inputs and expected outputs.
module tb_mc_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, zero, mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .illegal    (illegal),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
    int          ins;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  // exp = {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,
  //        ALUSrcB,ImmSrc,RegWrite,ALUControl,illegal}
  task automatic add(
    input logic rst, input logic [6:0] o, input logic [2:0] f3,
    input logic f7, input logic z, input logic rdy,
    input logic pcw, input logic adr, input logic mw, input logic irw,
    input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
    input logic [1:0] imm, input logic rw, input logic [2:0] alc,
    input logic ill, input int ins);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy;
    v.exp = {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alc, ill};
    v.ins = ins;
    vq.push_back(v);
  endtask

  initial begin
    logic [16:0] act;
    logic [31:0] exp_ins;
    reset = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;

    // reset held: FETCH outputs, writes forced low
    for (int k = 0; k < 3; k++)
      add(1,LW,0,0,0,1, 0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 0);
    // lw, no wait
    add(0,LW,0,0,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 0);
    add(0,LW,0,0,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0, 0);
    add(0,LW,0,0,0,1, 0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0, 0);
    add(0,LW,0,0,0,1, 0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0, 0);
    add(0,LW,0,0,0,1, 0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b000,0, 0);
    // sw, two wait cycles in MEMWRITE
    add(0,SW,2,0,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,3'b000,0, 1);
    add(0,SW,2,0,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,3'b000,0, 1);
    add(0,SW,2,0,0,1, 0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b000,0, 1);
    add(0,SW,2,0,0,0, 0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0, 1);
    add(0,SW,2,0,0,0, 0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0, 1);
    add(0,SW,2,0,0,1, 0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0, 1);
    // R-type sub, with one fetch wait
    add(0,RT,0,1,0,0, 0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 2);
    add(0,RT,0,1,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 2);
    add(0,RT,0,1,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0, 2);
    add(0,RT,0,1,0,1, 0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b001,0, 2);
    add(0,RT,0,1,0,1, 0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000,0, 2);
    // I-type addi with funct7b5=1 stays add
    add(0,IT,0,1,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 3);
    add(0,IT,0,1,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0, 3);
    add(0,IT,0,1,0,1, 0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0, 3);
    add(0,IT,0,1,0,1, 0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000,0, 3);
    // R-type xor, then I-type srli
    add(0,RT,4,0,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 4);
    add(0,RT,4,0,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0, 4);
    add(0,RT,4,0,0,1, 0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b110,0, 4);
    add(0,RT,4,0,0,1, 0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000,0, 4);
    add(0,IT,5,0,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 5);
    add(0,IT,5,0,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0, 5);
    add(0,IT,5,0,0,1, 0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b100,0, 5);
    add(0,IT,5,0,0,1, 0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000,0, 5);
    // beq taken
    add(0,BQ,0,0,1,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b000,0, 6);
    add(0,BQ,0,0,1,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b000,0, 6);
    add(0,BQ,0,0,1,1, 1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0, 6);
    // beq not taken
    add(0,BQ,0,0,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b000,0, 7);
    add(0,BQ,0,0,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b000,0, 7);
    add(0,BQ,0,0,0,1, 0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0, 7);
    // jal
    add(0,JL,0,0,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b11,0,3'b000,0, 8);
    add(0,JL,0,0,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b11,0,3'b000,0, 8);
    add(0,JL,0,0,0,1, 1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,3'b000,0, 8);
    add(0,JL,0,0,0,1, 0,0,0,0,2'b00,2'b00,2'b00,2'b11,1,3'b000,0, 8);
    // illegal opcode: pulse in DECODE, no retire
    add(0,BAD,0,0,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 9);
    add(0,BAD,0,0,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,1, 9);
    // lw aborted by reset in MEMREAD
    add(0,LW,0,0,0,1, 1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 9);
    add(0,LW,0,0,0,1, 0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0, 9);
    add(0,LW,0,0,0,1, 0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000,0, 9);
    add(0,LW,0,0,0,0, 0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0, 9);
    add(1,LW,0,0,0,1, 0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000,0, 0);
    add(0,LW,0,0,0,0, 0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 0);
    add(0,LW,0,0,0,0, 0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000,0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      reset     = vq[i].rst;
      op        = vq[i].op;
      funct3    = vq[i].f3;
      funct7b5  = vq[i].f7;
      zero      = vq[i].z;
      mem_ready = vq[i].rdy;
      #3;
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal};
      checks++;
      if (act !== vq[i].exp) begin
        errors++;
        $display("FAIL vec%0d outputs got=%b want=%b",
                 i, act, vq[i].exp);
      end
`ifdef MC_PERF_CNT_EN
      exp_ins = 32'(vq[i].ins);
`else
      exp_ins = 32'd0;
`endif
      checks++;
      if (instret !== exp_ins) begin
        errors++;
        $display("FAIL vec%0d instret got=%0d want=%0d",
                 i, instret, exp_ins);
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
